uart_word_rx: RTL
=================

# uart_word_rx

Serial-to-word receiver for the CPU↔FPGA UART link, on the FPGA side. It deserialises 8N1 frames from `uart_rx` and packs four consecutive bytes, little-endian, into one 32-bit word. It hands each word to the FPGA fabric over a valid/ready handshake and flags framing, overrun and inter-byte timeout errors. It is the receiving counterpart of the word transmitter that feeds `uart_tx` on the CPU side.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per bit time (50 MHz / 115200); legal range 8 or more.
- `TIMEOUT_BITS`, 20, idle bit-times allowed between bytes of a partially assembled word.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `uart_rx`  in  1  serial line, idle high; asynchronous to `clk`.
- `data_out`  out  32  assembled word; first received byte in [7:0].
- `data_valid`  out  1  `data_out` holds an unconsumed word.
- `data_ready`  in  1  consumer accepts the word when `data_valid && data_ready`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch; constant 0 when parity is compiled out.
- `overrun`  out  1  one-cycle pulse: a word completed while `data_valid` was high.
- `timeout_err`  out  1  one-cycle pulse: a partial word was discarded on inter-byte timeout.
- `busy`  out  1  high from start-bit detect until the frame ends (stop bit, or abort to BREAK).

## Operation
- `uart_rx` passes through a 2-flop synchroniser. The synchroniser flops reset to 1 (idle).
- Byte FSM states: IDLE, START, DATA, [PARITY], STOP, BREAK.
- IDLE → START on a synchronised falling edge.
- START waits `CLKS_PER_BIT/2` cycles, then samples. A low sample goes to DATA. A high sample is a glitch: return to IDLE with no error.
- DATA samples 8 bits, LSB first, one every `CLKS_PER_BIT` cycles. Each sample is taken at mid-bit.
- STOP samples once:
  - Sample high: byte accepted, go to IDLE.
  - Sample low: `frame_err` pulses, the byte and the partial word are discarded, go to BREAK.
- BREAK waits for the line to read high, then goes to IDLE.
- Word assembly:
  - A 2-bit byte index places each accepted byte into lane `index*8 +: 8`.
  - When index 3 is accepted, the word moves to the output register and the index wraps to 0.
- Output register:
  - Loads only when `data_valid` is 0, or when it is being consumed in the same cycle (accept and load together).
  - Otherwise the completed word is dropped, `overrun` pulses, and the held word is unchanged.
- Timeout:
  - A counter runs while index ≠ 0 and the FSM is in IDLE.
  - After `TIMEOUT_BITS*CLKS_PER_BIT` cycles: index cleared, `timeout_err` pulses.
  - The counter clears on each start-bit detect.
- Errors never block reception. The next valid start bit is always honoured.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, all error pulses 0, `busy`=0, FSM=IDLE, index=0.
- Line-to-FSM latency: 2 cycles (synchroniser).
- `data_valid` rises on the cycle after the 4th byte's stop-bit sample.
- A word is consumed on a clock edge where `data_valid && data_ready`. `data_valid` falls the next cycle unless a new word loads on that same edge.
- `data_out` is stable while `data_valid` is high and the word has not been consumed.
- Reset asserted mid-frame: everything returns to reset values immediately. A frame already in progress is not recovered. Reception resumes on the next falling edge seen after reset release.
- Bit counter width: ceil(log2(`CLKS_PER_BIT`)). Timeout counter width: ceil(log2(`TIMEOUT_BITS*CLKS_PER_BIT`+1)).

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP; even parity is checked.
  - On mismatch: `parity_err` pulses at the parity sample, the byte and the partial word are discarded, and the FSM still proceeds to STOP.
- Undefined: 8N1 only; `parity_err` is tied to 0.

## Structure
- Package `uart_pkg`:
  - FSM state enum.
  - `DATA_W`=32, `BYTES_PER_WORD`=4, `BYTE_W`=8.
- Sub-module `uart_rx_byte`: synchroniser, byte FSM and bit timing. Outputs are a byte, a byte-valid strobe and error strobes.
- `uart_word_rx` owns word assembly, the timeout counter and the output register.

## Test plan
- Bytes 0x78, 0x56, 0x34, 0x12 back-to-back, `data_ready`=1 → one word 0x12345678 with a 1-cycle `data_valid`; no errors.
- 0.3-bit low glitch on idle line → no `busy` beyond START, no output, no error.
- Frame with stop bit = 0 in byte 2, then 4 clean bytes 0xAA, 0xBB, 0xCC, 0xDD → one `frame_err`, then word 0xDDCCBBAA.
- `data_ready`=0, send two full words (0x11111111, 0x22222222) → `data_out` holds 0x11111111, one `overrun`; then raise `data_ready` → accepted, `data_valid` low.
- Send 2 bytes, idle for 21 bit-times, send 4 bytes 0x01–0x04 → one `timeout_err`, then word 0x04030201.
- With `UART_RX_PARITY_EN`: byte 0x07 with parity bit 0 (wrong) → `parity_err` pulse, index reset to 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and widths for the UART word receiver.
// Optional parity checking is enabled with UART_RX_PARITY_EN.
package uart_pkg;

  localparam int DATA_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W         = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// Synchroniser, byte FSM and bit timing for one serial frame.
// Defining UART_RX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              byte_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              start_det,
  output logic              idle,
  output logic              busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  rx_state_e         state_q, state_d;
  logic [2:0]        line_q, line_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] sh_q, sh_d;
  logic              perr_q, perr_d;
  logic              rxs;

  // line_q[1] is the synchronised line, line_q[2] its previous value
  assign rxs     = line_q[1];
  assign line_d  = {line_q[1:0], rx};
  assign rx_byte = sh_q;
  assign idle    = (state_q == S_IDLE);
  assign busy    = (state_q != S_IDLE) && (state_q != S_BREAK);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    sh_d       = sh_q;
    perr_d     = perr_q;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    parity_err = 1'b0;
    start_det  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (line_q[2] && !rxs) begin
          state_d   = S_START;
          start_det = 1'b1;
          perr_d    = 1'b0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          sh_d  = {rxs, sh_q[BYTE_W-1:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = S_STOP;
          if (^{sh_q, rxs}) begin
            parity_err = 1'b1;
            perr_d     = 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            state_d    = S_IDLE;
            byte_valid = !perr_q;
          end else begin
            state_d   = S_BREAK;
            frame_err = 1'b1;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      line_q  <= 3'b111;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      perr_q  <= perr_d;
    end
  end

endmodule

// File: rtl/uart_word_rx.sv
// Packs four UART bytes little-endian into a word with a valid/ready output.
// Parity checking is compiled in with UART_RX_PARITY_EN.
module uart_word_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              timeout_err,
  output logic              busy
);

  localparam int TMO   = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW    = $clog2(TMO + 1);
  localparam int LOW_W = BYTE_W * (BYTES_PER_WORD - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  logic [BYTE_W-1:0] rx_byte;
  logic              byte_valid, fe_s, pe_s, start_det, idle;

  logic [1:0]        idx_q, idx_d;
  logic [LOW_W-1:0]  word_q, word_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              fe_q, pe_q, ov_q, ov_d, to_q, to_d;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk       (clk),
    .reset     (reset),
    .rx        (uart_rx),
    .rx_byte   (rx_byte),
    .byte_valid(byte_valid),
    .frame_err (fe_s),
    .parity_err(pe_s),
    .start_det (start_det),
    .idle      (idle),
    .busy      (busy)
  );

  always_comb begin
    idx_d   = idx_q;
    word_d  = word_q;
    data_d  = data_q;
    valid_d = valid_q & ~data_ready;
    tmo_d   = tmo_q;
    ov_d    = 1'b0;
    to_d    = 1'b0;
    if (byte_valid) begin
      if (idx_q == 2'd3) begin
        idx_d = 2'd0;
        if (!valid_q || data_ready) begin
          data_d  = {rx_byte, word_q};
          valid_d = 1'b1;
        end else begin
          ov_d = 1'b1;
        end
      end else begin
        idx_d = idx_q + 2'd1;
        case (idx_q)
          2'd0:    word_d[7:0]   = rx_byte;
          2'd1:    word_d[15:8]  = rx_byte;
          default: word_d[23:16] = rx_byte;
        endcase
      end
    end
    if (fe_s || pe_s) idx_d = 2'd0;
    // only a partial word sitting between frames can time out
    if (start_det || idx_q == 2'd0) begin
      tmo_d = '0;
    end else if (idle) begin
      if (tmo_q == TMO_LAST) begin
        tmo_d = '0;
        idx_d = 2'd0;
        to_d  = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      tmo_q   <= '0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
      ov_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      word_q  <= word_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      fe_q    <= fe_s;
      pe_q    <= pe_s;
      ov_q    <= ov_d;
      to_q    <= to_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_err   = fe_q;
  assign parity_err  = pe_q;
  assign overrun     = ov_q;
  assign timeout_err = to_q;

endmodule
